// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster sync and test-pattern source for the filter pipeline
//
// Generates o_vs / o_hs / o_de with a per-frame shadowed test pattern.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   i_en               run request (level); sampled in IDLE and at frame end
//   i_pat_sel[1:0]     0 h-ramp, 1 v-ramp, 2 checker, 3 zero (latched at frame start)
//   o_vs, o_hs, o_de   vertical sync, horizontal sync, data enable
//   o_x, o_y           active column / line (0 outside o_de)
//   o_data             pattern pixel (0 outside o_de)
//   o_busy             high from frame start to frame end
//   o_frame_cnt[15:0]  frame counter, present only with VIDEO_TIMING_GEN_FRAME_CNT_EN
// All outputs are registered and lag the internal counters by one cycle.
module video_timing_gen #(
    parameter int CNT_H_SIZE = 12,
    parameter int CNT_V_SIZE = 12,
    parameter int HSY        = 1,
    parameter int HBP        = 3,
    parameter int HAC        = 1920,
    parameter int HFP        = 3,
    parameter int VSY        = 3,
    parameter int VBP        = 3,
    parameter int VAC        = 1080,
    parameter int VFP        = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_en,
    input  logic [1:0]            i_pat_sel,
    output logic                  o_vs,
    output logic                  o_hs,
    output logic                  o_de,
    output logic [CNT_H_SIZE-1:0] o_x,
    output logic [CNT_V_SIZE-1:0] o_y,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    ,
    output logic [15:0]           o_frame_cnt
`endif
);

    localparam int HTOT = HSY + HBP + HAC + HFP;
    localparam int VTOT = VSY + VBP + VAC + VFP;

    localparam logic [CNT_H_SIZE-1:0] H_LAST    = CNT_H_SIZE'(HTOT - 1);
    localparam logic [CNT_H_SIZE-1:0] H_SY_END  = CNT_H_SIZE'(HSY);
    localparam logic [CNT_H_SIZE-1:0] H_ACT_BEG = CNT_H_SIZE'(HSY + HBP);
    localparam logic [CNT_H_SIZE-1:0] H_ACT_END = CNT_H_SIZE'(HSY + HBP + HAC);
    localparam logic [CNT_V_SIZE-1:0] V_LAST    = CNT_V_SIZE'(VTOT - 1);
    localparam logic [CNT_V_SIZE-1:0] V_SY_END  = CNT_V_SIZE'(VSY);
    localparam logic [CNT_V_SIZE-1:0] V_ACT_BEG = CNT_V_SIZE'(VSY + VBP);
    localparam logic [CNT_V_SIZE-1:0] V_ACT_END = CNT_V_SIZE'(VSY + VBP + VAC);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        VACTIVE,
        VFRONT
    } state_t;

    state_t                r_state;
    logic [CNT_H_SIZE-1:0] r_cnt_h;
    logic [CNT_V_SIZE-1:0] r_cnt_v;
    logic [1:0]            r_pat;

    logic                  w_h_last;
    logic                  w_v_last;
    logic [CNT_V_SIZE-1:0] w_v_next;
    logic                  w_run;
    logic                  w_vs;
    logic                  w_hs;
    logic                  w_de;
    logic [CNT_H_SIZE-1:0] w_x;
    logic [CNT_V_SIZE-1:0] w_y;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_h_last = (r_cnt_h == H_LAST);
    assign w_v_last = (r_cnt_v == V_LAST);
    assign w_v_next = r_cnt_v + 1'b1;

    // Frame FSM and raster counters. Vertical transitions happen only on a
    // line wrap, so a falling i_en never truncates a line or a frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt_h <= '0;
            r_cnt_v <= '0;
            r_pat   <= 2'd0;
        end else if (r_state == IDLE) begin
            r_cnt_h <= '0;
            r_cnt_v <= '0;
            if (i_en) begin
                r_state <= VSYNC;
                r_pat   <= i_pat_sel;
            end
        end else if (!w_h_last) begin
            r_cnt_h <= r_cnt_h + 1'b1;
        end else begin
            r_cnt_h <= '0;
            r_cnt_v <= w_v_next;
            case (r_state)
                VSYNC:   if (w_v_next == V_SY_END)  r_state <= VBACK;
                VBACK:   if (w_v_next == V_ACT_BEG) r_state <= VACTIVE;
                VACTIVE: if (w_v_next == V_ACT_END) r_state <= VFRONT;
                VFRONT: begin
                    if (w_v_last) begin
                        r_cnt_v <= '0;
                        // Re-arming here keeps back-to-back frames gapless.
                        if (i_en) begin
                            r_state <= VSYNC;
                            r_pat   <= i_pat_sel;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_run = (r_state != IDLE);
    assign w_hs  = w_run && (r_cnt_h < H_SY_END);
    assign w_vs  = w_run && (r_cnt_v < V_SY_END);
    assign w_de  = (r_state == VACTIVE) && (r_cnt_h >= H_ACT_BEG) && (r_cnt_h < H_ACT_END);
    assign w_x   = r_cnt_h - H_ACT_BEG;
    assign w_y   = r_cnt_v - V_ACT_BEG;

    always_comb begin
        w_data = '0;
        case (r_pat)
            2'd0:    w_data = w_x[DATA_WIDTH-1:0];
            2'd1:    w_data = w_y[DATA_WIDTH-1:0];
            2'd2:    w_data = {DATA_WIDTH{w_x[5] ^ w_y[5]}};
            default: w_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_vs   <= 1'b0;
            o_hs   <= 1'b0;
            o_de   <= 1'b0;
            o_x    <= '0;
            o_y    <= '0;
            o_data <= '0;
            o_busy <= 1'b0;
        end else begin
            o_vs   <= w_vs;
            o_hs   <= w_hs;
            o_de   <= w_de;
            o_x    <= w_de ? w_x : '0;
            o_y    <= w_de ? w_y : '0;
            o_data <= w_de ? w_data : '0;
            o_busy <= w_run;
        end
    end

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Steps on the same edge that raises o_vs, so the new count and the
    // vsync rise appear together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_cnt <= 16'd0;
        end else if (w_vs && !o_vs) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen
module tb_video_timing_gen;

    localparam int HSY = 1, HBP = 3, HAC = 8, HFP = 3;
    localparam int VSY = 3, VBP = 3, VAC = 4, VFP = 3;
    localparam int HTOT = HSY + HBP + HAC + HFP;
    localparam int VTOT = VSY + VBP + VAC + VFP;
    localparam int NFR  = HTOT * VTOT;
    localparam int PER  = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_en = 1'b0;
    logic [1:0]  i_pat_sel = 2'd0;
    logic        o_vs, o_hs, o_de, o_busy;
    logic [11:0] o_x, o_y;
    logic [7:0]  o_data;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    video_timing_gen #(
        .CNT_H_SIZE(12), .CNT_V_SIZE(12),
        .HSY(HSY), .HBP(HBP), .HAC(HAC), .HFP(HFP),
        .VSY(VSY), .VBP(VBP), .VAC(VAC), .VFP(VFP),
        .DATA_WIDTH(8)
    ) dut (
        .clk(clk), .rstn(rstn), .i_en(i_en), .i_pat_sel(i_pat_sel),
        .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_x(o_x), .o_y(o_y),
        .o_data(o_data), .o_busy(o_busy)
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        , .o_frame_cnt(o_frame_cnt)
`endif
    );

    always #(PER/2) clk = ~clk;

    typedef struct packed {
        logic        vs, hs, de, busy;
        logic [11:0] x, y;
        logic [7:0]  data;
        logic [15:0] fc;
    } obs_t;

    obs_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference: a frame is NFR cycles, position p -> line p/HTOT, column p%HTOT.
    bit          m_act = 0;
    int          m_pos = 0;
    logic [1:0]  m_pat = 2'd0;
    logic [15:0] m_fc = 16'd0;

    function automatic obs_t expect_at(int pos, logic [1:0] pat, logic [15:0] fc);
        obs_t e;
        int line, col, x, y;
        e = '0;
        line = pos / HTOT;
        col  = pos % HTOT;
        e.busy = 1'b1;
        e.hs = (col < HSY);
        e.vs = (line < VSY);
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        e.fc = fc;
`else
        e.fc = 16'd0 & fc;
`endif
        if (line >= VSY + VBP && line < VSY + VBP + VAC &&
            col >= HSY + HBP && col < HSY + HBP + HAC) begin
            x = col - (HSY + HBP);
            y = line - (VSY + VBP);
            e.de = 1'b1;
            e.x = 12'(x);
            e.y = 12'(y);
            case (pat)
                2'd0: e.data = 8'(x);
                2'd1: e.data = 8'(y);
                2'd2: e.data = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 8'hFF : 8'h00;
                default: e.data = 8'h00;
            endcase
        end
        return e;
    endfunction

    // Stimulus side: each clock edge the model pushes what the DUT must show after it.
    always @(posedge clk) begin
        obs_t e;
        e = '0;
        if (!rstn) begin
            m_act = 0; m_pos = 0; m_pat = 2'd0; m_fc = 16'd0;
            expq.push_back(e);
        end else begin
            if (m_act) e = expect_at(m_pos, m_pat, m_fc);
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
            else e.fc = m_fc;
`endif
            expq.push_back(e);
            if (m_act && m_pos < NFR - 1) begin
                m_pos++;
            end else if (i_en) begin
                m_act = 1; m_pos = 0; m_pat = i_pat_sel; m_fc++;
            end else begin
                m_act = 0;
            end
        end
    end

    // Monitor side: pop and compare on the opposite edge.
    always @(negedge clk) begin
        obs_t e, o;
        if (expq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty @%0t: no expected entry, required one", $time);
        end else begin
            e = expq.pop_front();
            if (rstn) begin
                o = '0;
                o.vs = o_vs; o.hs = o_hs; o.de = o_de; o.busy = o_busy;
                o.x = o_x; o.y = o_y; o.data = o_data;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
                o.fc = o_frame_cnt;
`endif
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard @%0t: got vs%b hs%b de%b busy%b x%0d y%0d d%0h fc%0d, required vs%b hs%b de%b busy%b x%0d y%0d d%0h fc%0d",
                             $time, o.vs, o.hs, o.de, o.busy, o.x, o.y, o.data, o.fc,
                             e.vs, e.hs, e.de, e.busy, e.x, e.y, e.data, e.fc);
                end
            end
        end
    end

    // Aggregate counters for the frame-shape checks.
    int   s_vs = 0, s_de = 0, s_hs = 0, s_busy = 0;
    logic p_hs = 1'b0, p_vs = 1'b0;
    time  vs_rise[$];

    always @(negedge clk) begin
        if (o_vs) s_vs++;
        if (o_de) s_de++;
        if (o_busy) s_busy++;
        if (o_hs && !p_hs) s_hs++;
        if (o_vs && !p_vs) vs_rise.push_back($time);
        p_hs = o_hs;
        p_vs = o_vs;
    end

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_zero(input string name);
        logic [47:0] all;
        all = {o_vs, o_hs, o_de, o_busy, o_x, o_y, o_data, 4'd0};
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        all = all | {32'd0, o_frame_cnt};
`endif
        check(name, longint'(all), 0);
    endtask

    task automatic clear_stats();
        s_vs = 0; s_de = 0; s_hs = 0; s_busy = 0;
        vs_rise.delete();
    endtask

    initial begin
        time t0, t_rise, t_fall;
        bit  seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_zero("reset_outputs");
        @(negedge clk); #1 rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Single-cycle i_en pulse: exactly one frame
        clear_stats();
        #1 i_en = 1'b1; i_pat_sel = 2'd0;
        @(posedge clk); t0 = $time;
        #1 i_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (o_vs) begin seen = 1; t_rise = $time; end
        end
        check("vs_rise_seen", seen, 1);
        if (seen) begin
            check("vs_rise_latency", longint'(t_rise - t0), PER + PER/2);
            check("hs_with_vs", o_hs, 1);
        end
        seen = 0;
        for (int i = 0; i < NFR + 50 && !seen; i++) begin
            @(negedge clk);
            if (!o_busy) begin seen = 1; t_fall = $time; end
        end
        check("busy_fall_seen", seen, 1);
        if (seen) check("busy_fall_time", longint'(t_fall - t_rise), NFR * PER);
        check("busy_cycles", s_busy, NFR);
        check("vs_cycles", s_vs, VSY * HTOT);
        check("hs_pulses", s_hs, VTOT);
        check("de_cycles", s_de, HAC * VAC);
        repeat (30) @(negedge clk);
        check("idle_after_one_frame", o_busy, 0);
        check("one_vs_rise", vs_rise.size(), 1);

        // Held i_en: back-to-back frames, mid-frame pattern switch 0 -> 1
        clear_stats();
        #1 i_en = 1'b1; i_pat_sel = 2'd0;
        repeat (NFR / 2) @(negedge clk);
        #1 i_pat_sel = 2'd1;
        repeat (2 * NFR + 20) @(negedge clk);
        check("vs_rises_b2b", vs_rise.size(), 3);
        if (vs_rise.size() >= 3) begin
            check("vs_period_1", longint'(vs_rise[1] - vs_rise[0]), NFR * PER);
            check("vs_period_2", longint'(vs_rise[2] - vs_rise[1]), NFR * PER);
        end

        // Asynchronous reset during active line 2
        seen = 0;
        for (int i = 0; i < 2 * NFR && !seen; i++) begin
            @(negedge clk);
            if (o_de && o_y == 12'd2) seen = 1;
        end
        check("reached_line2", seen, 1);
        #2 rstn = 1'b0;
        #1 check_zero("async_reset_zero");
        repeat (2) @(negedge clk);
        check_zero("reset_held_zero");
        #1 rstn = 1'b1;
        clear_stats();
        repeat (NFR + 10) @(negedge clk);
        check("restart_vs_rise", vs_rise.size() >= 1, 1);

        // Randomised run/stop and pattern traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(39) == 0) i_en = ~i_en;
            if ($urandom_range(59) == 0) i_pat_sel = 2'($urandom_range(3));
        end
        #1 i_en = 1'b0;
        seen = 0;
        for (int i = 0; i < NFR + 20 && !seen; i++) begin
            @(negedge clk);
            if (!o_busy) seen = 1;
        end
        check("final_idle", seen, 1);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
